free_list: RTL and testbench

//  Circular FIFO of free physical register tags feeding rename. Supplies new

---
 rtl/free_list.sv | 124 ++++++++++++
 tb/tb_free_list.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Circular free list of physical register tags for rename, with speculative/committed head and mispredict rewind.
// Optional FREE_LIST_CHECK_EN adds a sticky dbg_error output for overflow and tag-0 frees.

module free_list_lane #(
  parameter int WIDTH = 3,
  parameter int LANE  = 0,
  parameter int TAG_W = 6
) (
  input  logic [WIDTH-1:0] alloc_req,
  input  logic [WIDTH-1:0] free_en,
  input  logic [TAG_W-1:0] head_lo,
  input  logic [TAG_W-1:0] tail_lo,
  output logic [TAG_W-1:0] rd_idx,
  output logic [TAG_W-1:0] wr_idx
);
  // Each lane offsets its slot by the number of active lower-numbered lanes.
  always_comb begin
    rd_idx = head_lo;
    wr_idx = tail_lo;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < LANE) begin
        rd_idx = rd_idx + TAG_W'(alloc_req[j]);
        wr_idx = wr_idx + TAG_W'(free_en[j]);
      end
    end
  end
endmodule

module free_list #(
  parameter int WIDTH     = 3,
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  localparam int TAG_W    = $clog2(PHYS_REGS),
  localparam int PW       = TAG_W + 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [WIDTH-1:0]            alloc_req,
  output logic [WIDTH-1:0][TAG_W-1:0] alloc_tags,
  output logic                        alloc_ok,
  output logic [PW-1:0]               avail_count,
  input  logic [WIDTH-1:0]            free_en,
  input  logic [WIDTH-1:0][TAG_W-1:0] free_tags,
`ifdef FREE_LIST_CHECK_EN
  output logic                        dbg_error,
`endif
  input  logic                        mispredict
);
  localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;

  function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) popcnt = popcnt + PW'(v[i]);
  endfunction

  logic [TAG_W-1:0] mem [PHYS_REGS];
  logic [PW-1:0] head, arch_head, tail;
  logic [PW-1:0] head_n, arch_head_n, tail_n, n_alloc, n_free;
  logic [WIDTH-1:0][TAG_W-1:0] rd_idx, wr_idx;

  assign avail_count = tail - head;
  assign n_alloc     = popcnt(alloc_req);
  assign n_free      = popcnt(free_en);
  assign alloc_ok    = (n_alloc <= avail_count);
  assign arch_head_n = arch_head + n_free;
  assign tail_n      = tail + n_free;
  // Rewind lands on the committed head after this cycle's retires.
  assign head_n      = mispredict ? arch_head_n : (alloc_ok ? head + n_alloc : head);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    free_list_lane #(.WIDTH(WIDTH), .LANE(i), .TAG_W(TAG_W)) u_lane (
      .alloc_req (alloc_req),
      .free_en   (free_en),
      .head_lo   (head[TAG_W-1:0]),
      .tail_lo   (tail[TAG_W-1:0]),
      .rd_idx    (rd_idx[i]),
      .wr_idx    (wr_idx[i])
    );
    assign alloc_tags[i] = alloc_req[i] ? mem[rd_idx[i]] : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= PW'(INIT_FREE);
    end else begin
      head      <= head_n;
      arch_head <= arch_head_n;
      tail      <= tail_n;
    end
  end

  // Writes land behind tail, so this cycle's reads never see them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < PHYS_REGS; k++)
        mem[k] <= (k < INIT_FREE) ? TAG_W'(ARCH_REGS + k) : '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (free_en[i]) mem[wr_idx[i]] <= free_tags[i];
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic err;
  always_comb begin
    err = 1'b0;
    if ((tail_n - head_n) > PW'(PHYS_REGS - 1)) err = 1'b1;
    for (int i = 0; i < WIDTH; i++)
      if (free_en[i] && free_tags[i] == '0) err = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dbg_error <= 1'b0;
    else if (err) begin
      dbg_error <= 1'b1;
`ifndef SYNTHESIS
      $error("free_list: overflow or tag-0 free");
`endif
    end
  end
`endif
endmodule

// File: tb/tb_free_list.sv
// Randomized + directed bench for free_list, checked against a queue model of the committed free region.
module tb_free_list;
  localparam int W = 3, PR = 64, AR = 32, TW = 6;

  logic                 clock, reset_n, alloc_ok, mispredict;
  logic [W-1:0]         alloc_req, free_en;
  logic [W-1:0][TW-1:0] alloc_tags, free_tags;
  logic [TW:0]          avail_count;

  int total = 0, bad = 0;
  int q[$];    // tags from committed head to tail, in FIFO order
  int spec_n;  // speculative allocations taken from the front of q

  free_list #(.WIDTH(W), .PHYS_REGS(PR), .ARCH_REGS(AR)) dut (
    .clock(clock), .reset_n(reset_n), .alloc_req(alloc_req), .alloc_tags(alloc_tags),
    .alloc_ok(alloc_ok), .avail_count(avail_count), .free_en(free_en),
    .free_tags(free_tags), .mispredict(mispredict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pc(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += v[i];
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < PR - AR; k++) q.push_back(AR + k);
    spec_n = 0;
  endtask

  task automatic check_outputs();
    int na, k;
    bit ok;
    na = pc(alloc_req);
    ok = (na <= (PR - AR) - spec_n);
    chk("avail", 32'(avail_count), 32'((PR - AR) - spec_n));
    chk("ok", 32'(alloc_ok), 32'(ok));
    if (ok) begin
      k = 0;
      for (int i = 0; i < W; i++) begin
        if (alloc_req[i]) begin chk("tag", 32'(alloc_tags[i]), 32'(q[spec_n + k])); k++; end
        else chk("tag_idle", 32'(alloc_tags[i]), 32'd0);
      end
    end
  endtask

  task automatic model_step();
    int na, nf, nxt;
    na  = pc(alloc_req);
    nf  = pc(free_en);
    nxt = spec_n + (((na <= (PR - AR) - spec_n) && !mispredict) ? na : 0);
    for (int i = 0; i < W; i++) if (free_en[i]) q.push_back(int'(free_tags[i]));
    repeat (nf) void'(q.pop_front());
    nxt -= nf;
    spec_n = mispredict ? 0 : nxt;
  endtask

  // Inputs are set just after a rising edge; check mid-cycle, then advance.
  task automatic cycle();
    #4;
    check_outputs();
    model_step();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    alloc_req = '0; free_en = '0; free_tags = '0; mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic rand_inputs();
    logic [W-1:0] fe;
    alloc_req  = W'($urandom);
    mispredict = ($urandom_range(15) == 0);
    fe = W'($urandom);
    for (int i = W - 1; i >= 0; i--) if (pc(fe) > spec_n) fe[i] = 1'b0;
    free_en = fe;
    for (int i = 0; i < W; i++) free_tags[i] = TW'($urandom_range(PR - 1, 1));
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    #12 reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset state and first triple allocation
    #1;
    chk("rst_avail", 32'(avail_count), 32'd32);
    chk("rst_ok", 32'(alloc_ok), 32'd1);
    alloc_req = 3'b111; #1;
    chk("t111_0", 32'(alloc_tags[0]), 32'd32);
    chk("t111_1", 32'(alloc_tags[1]), 32'd33);
    chk("t111_2", 32'(alloc_tags[2]), 32'd34);
    cycle();
    idle(); #1;
    chk("avail29", 32'(avail_count), 32'd29);

    // Sparse request packs onto consecutive tags
    do_reset();
    alloc_req = 3'b101; #1;
    chk("t101_0", 32'(alloc_tags[0]), 32'd32);
    chk("t101_1", 32'(alloc_tags[1]), 32'd0);
    chk("t101_2", 32'(alloc_tags[2]), 32'd33);
    cycle();
    alloc_req = 3'b001; #1;
    chk("t001", 32'(alloc_tags[0]), 32'd34);
    cycle();

    // Exhaust, stall, and grant a freshly freed tag one cycle later
    do_reset();
    for (int c = 0; c < 10; c++) begin alloc_req = 3'b111; cycle(); end
    alloc_req = 3'b011; cycle();
    alloc_req = 3'b001; free_en = 3'b001; free_tags[0] = 6'd5; #1;
    chk("empty_ok", 32'(alloc_ok), 32'd0);
    chk("empty_avail", 32'(avail_count), 32'd0);
    cycle();
    idle(); alloc_req = 3'b001; #1;
    chk("freed5", 32'(alloc_tags[0]), 32'd5);
    chk("freed5_avail", 32'(avail_count), 32'd1);
    cycle();

    // Mispredict with same-cycle retires
    do_reset();
    alloc_req = 3'b111; cycle();
    alloc_req = 3'b111; cycle();
    idle(); free_en = 3'b011; free_tags[0] = 6'd7; free_tags[1] = 6'd9; mispredict = 1'b1;
    alloc_req = 3'b111;
    cycle();
    idle(); alloc_req = 3'b001; #1;
    chk("mp_avail", 32'(avail_count), 32'd32);
    chk("mp_tag", 32'(alloc_tags[0]), 32'd34);
    cycle();

    // Wrap: steady alloc/free pairs of three
    do_reset();
    alloc_req = 3'b111; cycle();
    for (int c = 0; c < 100; c++) begin
      alloc_req = 3'b111; free_en = 3'b111;
      for (int i = 0; i < W; i++) free_tags[i] = TW'($urandom_range(PR - 1, 1));
      cycle();
    end
    idle(); mispredict = 1'b1; cycle();
    idle(); #1;
    chk("wrap_avail", 32'(avail_count), 32'd32);

    // Random traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin rand_inputs(); cycle(); end

    // Reset asserted mid-burst takes effect before the next edge
    for (int c = 0; c < 5; c++) begin alloc_req = 3'b111; cycle(); end
    alloc_req = 3'b111; reset_n = 1'b0; #1;
    model_reset();
    chk("mid_avail", 32'(avail_count), 32'd32);
    chk("mid_ok", 32'(alloc_ok), 32'd1);
    chk("mid_t0", 32'(alloc_tags[0]), 32'd32);
    chk("mid_t2", 32'(alloc_tags[2]), 32'd34);
    idle(); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 100; c++) begin rand_inputs(); cycle(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
